// File: rtl/mem_fill_arbiter.sv
// mem_fill_arbiter
//   Miss-handling controller shared by the I-cache and D-cache. Arbitrates
//   one miss at a time onto the single main-memory read port (D side wins),
//   issues WORDS consecutive word reads for the aligned block, steers the
//   in-order returns into the owning cache, and produces the pipeline
//   freeze (pipe_write_en) and fetch stall (if_stall).
//
// Ports
//   clk, rst_n          : clock, asynchronous active-low reset
//   if_miss / if_addr   : I-cache miss level and byte address
//   mem_miss / mem_addr : D-cache miss level and byte address
//   mem_data_valid      : one returning word this cycle (request order)
//   mem_req / mem_req_addr : read request and its address
//   fill_icache / fill_dcache / fill_word : write strobe and block index
//   done_i / done_d     : one-cycle completion pulses
//   pipe_write_en       : enable for all pipeline registers
//   if_stall            : hold PC, bubble into IF/ID
module mem_fill_arbiter #(
  parameter int WORDS = 8,
  parameter int LAT   = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     if_miss,
  input  logic [15:0]              if_addr,
  input  logic                     mem_miss,
  input  logic [15:0]              mem_addr,
  input  logic                     mem_data_valid,
  output logic                     mem_req,
  output logic [15:0]              mem_req_addr,
  output logic                     fill_icache,
  output logic                     fill_dcache,
  output logic [$clog2(WORDS)-1:0] fill_word,
  output logic                     done_i,
  output logic                     done_d,
  output logic                     pipe_write_en,
  output logic                     if_stall
);

  localparam int WW = $clog2(WORDS);
  localparam int CW = WW + 1;  // counters must be able to hold WORDS
  localparam logic [15:0] ADDR_MASK = ~16'(2 * WORDS - 1);

  // LAT describes the memory the controller is paired with; the controller
  // itself only counts returns, so LAT is only sanity-checked here.
  if (WORDS < 2 || WORDS > 16 || (WORDS & (WORDS - 1)) != 0 || LAT < 1) begin : g_bad_param
    $error("mem_fill_arbiter: WORDS must be a power of two in 2..16 and LAT >= 1");
  end

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FILL_I = 2'd1,
    FILL_D = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic            side_d_q, side_d_d;  // 1: block belongs to the D-cache
  logic [15:0]     base_q, base_d;
  logic [CW-1:0]   issue_cnt_q, issue_cnt_d;
  logic [CW-1:0]   ret_cnt_q, ret_cnt_d;
  logic            in_fill;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      side_d_q    <= 1'b0;
      base_q      <= '0;
      issue_cnt_q <= '0;
      ret_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      side_d_q    <= side_d_d;
      base_q      <= base_d;
      issue_cnt_q <= issue_cnt_d;
      ret_cnt_q   <= ret_cnt_d;
    end
  end

  assign in_fill = (state_q == FILL_I) || (state_q == FILL_D);

  // Next-state logic
  always_comb begin
    state_d     = state_q;
    side_d_d    = side_d_q;
    base_d      = base_q;
    issue_cnt_d = issue_cnt_q;
    ret_cnt_d   = ret_cnt_q;
    unique case (state_q)
      IDLE: begin
        issue_cnt_d = '0;
        ret_cnt_d   = '0;
        if (mem_miss) begin
          state_d  = FILL_D;
          side_d_d = 1'b1;
          base_d   = mem_addr & ADDR_MASK;
        end else if (if_miss) begin
          state_d  = FILL_I;
          side_d_d = 1'b0;
          base_d   = if_addr & ADDR_MASK;
        end
      end
      FILL_I, FILL_D: begin
        if (issue_cnt_q < CW'(WORDS)) begin
          issue_cnt_d = issue_cnt_q + 1'b1;
        end
        if (mem_data_valid) begin
          ret_cnt_d = ret_cnt_q + 1'b1;
          // Leaving on the last return means no further valid can be
          // counted against this block.
          if (ret_cnt_q == CW'(WORDS - 1)) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Output logic
  always_comb begin
    mem_req      = in_fill && (issue_cnt_q < CW'(WORDS));
    // Offset is added modulo 2^16: a block at 0xFFF0 never spills to 0x0000.
    mem_req_addr = mem_req ? (base_q + (16'(issue_cnt_q) << 1)) : 16'h0000;
    fill_icache  = (state_q == FILL_I) && mem_data_valid;
    fill_dcache  = (state_q == FILL_D) && mem_data_valid;
    fill_word    = (fill_icache || fill_dcache) ? ret_cnt_q[WW-1:0] : '0;
    done_i       = (state_q == DONE) && !side_d_q;
    done_d       = (state_q == DONE) && side_d_q;
    // A D miss freezes the whole pipeline from the moment it is raised;
    // an I miss only holds fetch.
    pipe_write_en = ~(mem_miss | (state_q == FILL_D));
    if_stall      = ~pipe_write_en | if_miss | (state_q == FILL_I);
  end

endmodule

// File: tb/tb_mem_fill_arbiter.sv
module tb_mem_fill_arbiter;
  localparam int WORDS = 8;
  localparam int LAT   = 4;

  logic        clk;
  logic        rst_n;
  logic        if_miss, mem_miss, mem_data_valid;
  logic [15:0] if_addr, mem_addr;
  logic        mem_req, fill_icache, fill_dcache, done_i, done_d;
  logic        pipe_write_en, if_stall;
  logic [15:0] mem_req_addr;
  logic [2:0]  fill_word;

  mem_fill_arbiter #(.WORDS(WORDS), .LAT(LAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_miss(if_miss), .if_addr(if_addr),
    .mem_miss(mem_miss), .mem_addr(mem_addr),
    .mem_data_valid(mem_data_valid),
    .mem_req(mem_req), .mem_req_addr(mem_req_addr),
    .fill_icache(fill_icache), .fill_dcache(fill_dcache), .fill_word(fill_word),
    .done_i(done_i), .done_d(done_d),
    .pipe_write_en(pipe_write_en), .if_stall(if_stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Reference model: a block job described by its acceptance cycle.
  bit          m_busy = 0;
  bit          m_side = 0;     // 1 = D block
  int          m_acc  = 0;
  int          m_rets = 0;
  int          m_done_at = -1;
  logic [15:0] m_base = '0;

  // Memory model: cycles at which a requested word comes back.
  int mq[$];

  // CPU-side requests
  bit i_pend = 0, d_pend = 0;
  int last_dd = -1, last_di = -1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  function automatic logic [15:0] rand_addr();
    logic [15:0] a;
    a = 16'($urandom);
    if ($urandom_range(0, 3) == 0) a = 16'hFFF0 | (a & 16'h000F);
    return a;
  endfunction

  task automatic drive(input bit stray_ok);
    if_miss = i_pend;
    mem_miss = d_pend;
    mem_data_valid = 1'b0;
    if (mq.size() > 0 && mq[0] == cyc) begin
      mem_data_valid = 1'b1;
      void'(mq.pop_front());
    end else if (stray_ok && (!m_busy || m_done_at == cyc) && $urandom_range(0, 3) == 0) begin
      mem_data_valid = 1'b1;
    end
  endtask

  task automatic eval();
    bit in_rst, donec, fillc, e_req, e_fi, e_fd, e_pwe, e_ifs;
    int k;
    logic [15:0] a;
    in_rst = (rst_n === 1'b0);
    donec  = m_busy && !in_rst && (m_done_at == cyc);
    fillc  = m_busy && !in_rst && !donec;
    k      = cyc - m_acc;
    e_req  = fillc && k >= 1 && k <= WORDS;
    e_fi   = fillc && !m_side && mem_data_valid;
    e_fd   = fillc && m_side && mem_data_valid;
    e_pwe  = !(mem_miss || (fillc && m_side));
    e_ifs  = !e_pwe || if_miss || (fillc && !m_side);

    chk("mem_req", 32'(mem_req), 32'(e_req));
    if (e_req) chk("mem_req_addr", 32'(mem_req_addr), 32'(m_base + 16'(2 * (k - 1))));
    chk("fill_icache", 32'(fill_icache), 32'(e_fi));
    chk("fill_dcache", 32'(fill_dcache), 32'(e_fd));
    if (e_fi || e_fd) chk("fill_word", 32'(fill_word), 32'(m_rets));
    chk("done_i", 32'(done_i), 32'(donec && !m_side));
    chk("done_d", 32'(done_d), 32'(donec && m_side));
    chk("pipe_write_en", 32'(pipe_write_en), 32'(e_pwe));
    chk("if_stall", 32'(if_stall), 32'(e_ifs));
    $display("cyc=%0d rst_n=%0b im=%0b dm=%0b v=%0b req=%0b addr=%h fi=%0b fd=%0b w=%0d di=%0b dd=%0b pwe=%0b ifs=%0b",
             cyc, rst_n, if_miss, mem_miss, mem_data_valid, mem_req, mem_req_addr,
             fill_icache, fill_dcache, fill_word, done_i, done_d, pipe_write_en, if_stall);

    if (done_d === 1'b1) last_dd = cyc;
    if (done_i === 1'b1) last_di = cyc;
    if (mem_req === 1'b1) mq.push_back(cyc + LAT);

    if (in_rst) begin
      m_busy = 0;
    end else if (donec) begin
      m_busy = 0;
      if (m_side) d_pend = 0; else i_pend = 0;
    end else if (fillc) begin
      if (mem_data_valid) begin
        m_rets++;
        if (m_rets == WORDS) m_done_at = cyc + 1;
      end
    end else if (mem_miss || if_miss) begin
      m_side = mem_miss;
      a = mem_miss ? mem_addr : if_addr;
      m_base = a & ~16'(2 * WORDS - 1);
      m_acc = cyc;
      m_rets = 0;
      m_done_at = -1;
      m_busy = 1;
    end
  endtask

  task automatic run(input int n, input bit rnd, input bit stray);
    for (int i = 0; i < n; i++) begin
      if (rnd) begin
        if (!d_pend && !(m_busy && m_side) && $urandom_range(0, 11) == 0) begin
          d_pend = 1; mem_addr = rand_addr();
        end
        if (!i_pend && !(m_busy && !m_side) && $urandom_range(0, 9) == 0) begin
          i_pend = 1; if_addr = rand_addr();
        end
        if (d_pend && m_busy && m_side && m_done_at != cyc && $urandom_range(0, 29) == 0) d_pend = 0;
        if (i_pend && m_busy && !m_side && m_done_at != cyc && $urandom_range(0, 29) == 0) i_pend = 0;
      end
      drive(stray);
      @(negedge clk);
      eval();
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  initial begin
    int t0;
    rst_n = 1'b0;
    if_miss = 0; mem_miss = 0; mem_data_valid = 0;
    if_addr = '0; mem_addr = '0;
    @(posedge clk); #1;
    run(2, 0, 0);
    rst_n = 1'b1;
    run(2, 0, 0);

    // D miss only
    d_pend = 1; mem_addr = 16'h1236; t0 = cyc;
    run(16, 0, 0);
    chk("d_only_done_cycle", 32'(last_dd - t0), 32'd13);

    // I miss only
    i_pend = 1; if_addr = 16'h00A4; t0 = cyc;
    run(16, 0, 0);
    chk("i_only_done_cycle", 32'(last_di - t0), 32'd13);

    // Simultaneous: D first, I accepted the cycle after done_d
    i_pend = 1; if_addr = 16'h0342; d_pend = 1; mem_addr = 16'h7718; t0 = cyc;
    run(30, 0, 0);
    chk("simul_done_d_cycle", 32'(last_dd - t0), 32'd13);
    chk("simul_done_i_gap", 32'(last_di - last_dd), 32'd14);

    // Address wrap
    d_pend = 1; mem_addr = 16'hFFFC;
    run(16, 0, 0);

    // Stray valids while idle, then a fresh fill
    run(8, 0, 1);
    i_pend = 1; if_addr = 16'h2000;
    run(16, 0, 1);

    // Reset after three fills
    d_pend = 1; mem_addr = 16'h4442;
    for (int i = 0; i < 40 && m_rets < 3; i++) run(1, 0, 0);
    chk("reset_setup_fills", 32'(m_rets >= 3), 32'd1);
    rst_n = 1'b0; d_pend = 0; i_pend = 0;
    run(1, 0, 0);
    rst_n = 1'b1;
    run(LAT + 4, 0, 0);
    d_pend = 1; mem_addr = 16'h0810;
    run(16, 0, 0);

    // Randomized traffic, then drain
    run(3000, 1, 1);
    run(60, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
